// File: rtl/dz_pkg.sv
// Shared types and helpers for the countdown sequencer.
//   state_e    : sequencer states
//   COL_*      : colour codes understood by the display driver
//   num_color  : digit -> colour mapping used while not idle
package dz_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } state_e;

  localparam logic [1:0] COL_OFF = 2'b00;
  localparam logic [1:0] COL_RED = 2'b01;
  localparam logic [1:0] COL_GRN = 2'b10;
  localparam logic [1:0] COL_YEL = 2'b11;

  function automatic logic [1:0] num_color(input logic [2:0] n);
    if (n >= 3'd4) begin
      return COL_RED;
    end else if (n >= 3'd2) begin
      return COL_GRN;
    end else begin
      return COL_YEL;
    end
  endfunction

endpackage

// File: rtl/dz_countdown_if.sv
// Board-facing bundle of the countdown sequencer.
//   btn_start, btn_pause : raw push-buttons (driven by the master / board side)
//   num, color           : digit and colour towards the display driver
//   running, done        : status (running level, single-cycle done pulse)
interface dz_countdown_if;

  logic       btn_start;
  logic       btn_pause;
  logic [2:0] num;
  logic [1:0] color;
  logic       running;
  logic       done;

  modport master (
    output btn_start,
    output btn_pause,
    input  num,
    input  color,
    input  running,
    input  done
  );

  modport slave (
    input  btn_start,
    input  btn_pause,
    output num,
    output color,
    output running,
    output done
  );

endinterface

// File: rtl/dz_debounce.sv
// Button conditioner: 2-FF synchroniser, debounce counter, rising-edge pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw button level, asynchronous to clk
//   pulse      : one-cycle pulse when the accepted level rises
module dz_debounce #(
  parameter int unsigned DEB_CYC = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CntMax = CW'(DEB_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      // Any cycle agreeing with the accepted level restarts qualification.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        pulse_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/dz_countdown.sv
// Countdown sequencer feeding the dot-matrix display driver.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of dz_countdown_if
//                (buttons in; num, color, running, done out, all registered)
// Counts START_VAL down to 0, one step per TICK_DIV cycles in RUN; holds a
// zero digit for one full period before entering DONE.
module dz_countdown
  import dz_pkg::*;
#(
  parameter int unsigned START_VAL = 5,
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned DEB_CYC   = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  dz_countdown_if.slave  bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PreMax = PW'(TICK_DIV - 1);
  localparam logic [2:0] StartNum = 3'(START_VAL);

  logic start_p;
  logic pause_p;

  state_e        state_q;
  logic [2:0]    num_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    color_q;
  logic          running_q;
  logic          done_q;

  dz_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_deb_start (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (bus.btn_start),
    .pulse(start_p)
  );

  dz_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_deb_pause (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (bus.btn_pause),
    .pulse(pause_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      num_q     <= StartNum;
      presc_q   <= '0;
      color_q   <= COL_OFF;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // start_p restarts from every state and beats pause_p and a tick wrap.
      if (start_p) begin
        state_q   <= StRun;
        num_q     <= StartNum;
        presc_q   <= '0;
        color_q   <= num_color(StartNum);
        running_q <= 1'b1;
      end else begin
        case (state_q)
          StRun: begin
            if (pause_p) begin
              state_q   <= StPause;
              running_q <= 1'b0;
            end else if (presc_q == PreMax) begin
              presc_q <= '0;
              if (num_q != 3'd0) begin
                num_q   <= num_q - 3'd1;
                color_q <= num_color(num_q - 3'd1);
              end else begin
                state_q   <= StDone;
                running_q <= 1'b0;
                done_q    <= 1'b1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          StPause: begin
            // Prescaler is left untouched so the period resumes mid-way.
            if (pause_p) begin
              state_q   <= StRun;
              running_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.num     = num_q;
  assign bus.color   = color_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_dz_countdown.sv
// Directed bench for dz_countdown (START_VAL=5, TICK_DIV=4, DEB_CYC=2).
// Expected outputs are queued with the cycle they are due when stimulus is
// applied, and compared when that cycle is reached.
module tb_dz_countdown;

  logic clk;
  logic rst_n;

  dz_countdown_if bus ();

  dz_countdown #(
    .START_VAL(5),
    .TICK_DIV (4),
    .DEB_CYC  (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  num;
    logic [1:0]  color;
    logic        running;
    logic        done;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc_cnt;
  int unsigned done_seen;
  int unsigned checks;
  int unsigned errors;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_at(input int unsigned c, input logic [2:0] n, input logic [1:0] col,
                           input logic run, input logic dn, input string tag);
    exp_t e;
    e.cyc = c;
    e.num = n;
    e.color = col;
    e.running = run;
    e.done = dn;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e = sb.pop_front();
      chk($sformatf("%s.num@%0d", e.tag, cyc_cnt), 8'(bus.num), 8'(e.num));
      chk($sformatf("%s.color@%0d", e.tag, cyc_cnt), 8'(bus.color), 8'(e.color));
      chk($sformatf("%s.running@%0d", e.tag, cyc_cnt), 8'(bus.running), 8'(e.running));
      chk($sformatf("%s.done@%0d", e.tag, cyc_cnt), 8'(bus.done), 8'(e.done));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_cnt++;
    if (bus.done === 1'b1) done_seen++;
    drain();
  endtask

  task automatic run(input int unsigned n);
    repeat (n) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b;
    int unsigned q;
    cyc_cnt = 0;
    done_seen = 0;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;

    // Reset state
    run(2);
    expect_at(cyc_cnt, 3'd5, 2'b00, 1'b0, 1'b0, "reset");
    drain();
    rst_n = 1'b1;

    // Glitching start button never qualifies
    b = cyc_cnt;
    expect_at(b + 4, 3'd5, 2'b00, 1'b0, 1'b0, "glitch");
    expect_at(b + 10, 3'd5, 2'b00, 1'b0, 1'b0, "glitch");
    expect_at(b + 20, 3'd5, 2'b00, 1'b0, 1'b0, "glitch");
    expect_at(b + 24, 3'd5, 2'b00, 1'b0, 1'b0, "glitch");
    for (int i = 0; i < 20; i++) begin
      bus.btn_start = (i % 2 == 0);
      step();
    end
    bus.btn_start = 1'b0;
    run(4);

    // Full countdown to DONE
    b = cyc_cnt;
    done_seen = 0;
    expect_at(b + 4, 3'd5, 2'b00, 1'b0, 1'b0, "start_lat");
    expect_at(b + 5, 3'd5, 2'b01, 1'b1, 1'b0, "run5");
    expect_at(b + 8, 3'd5, 2'b01, 1'b1, 1'b0, "hold5");
    expect_at(b + 9, 3'd4, 2'b01, 1'b1, 1'b0, "run4");
    expect_at(b + 13, 3'd3, 2'b10, 1'b1, 1'b0, "run3");
    expect_at(b + 17, 3'd2, 2'b10, 1'b1, 1'b0, "run2");
    expect_at(b + 21, 3'd1, 2'b11, 1'b1, 1'b0, "run1");
    expect_at(b + 25, 3'd0, 2'b11, 1'b1, 1'b0, "run0");
    expect_at(b + 28, 3'd0, 2'b11, 1'b1, 1'b0, "hold0");
    expect_at(b + 29, 3'd0, 2'b11, 1'b0, 1'b1, "done");
    expect_at(b + 30, 3'd0, 2'b11, 1'b0, 1'b0, "done_end");
    bus.btn_start = 1'b1;
    run(6);
    bus.btn_start = 1'b0;
    run(30);
    chk("done_count_a", 8'(done_seen), 8'd1);

    // Pause in DONE is ignored
    b = cyc_cnt;
    done_seen = 0;
    expect_at(b + 6, 3'd0, 2'b11, 1'b0, 1'b0, "done_pause");
    expect_at(b + 10, 3'd0, 2'b11, 1'b0, 1'b0, "done_pause");
    bus.btn_pause = 1'b1;
    run(3);
    bus.btn_pause = 1'b0;
    run(7);
    chk("done_count_b", 8'(done_seen), 8'd0);

    // Restart from DONE, pause at num=3 / prescaler=2, resume
    b = cyc_cnt;
    expect_at(b + 4, 3'd0, 2'b11, 1'b0, 1'b0, "restart_lat");
    expect_at(b + 5, 3'd5, 2'b01, 1'b1, 1'b0, "restart");
    expect_at(b + 9, 3'd4, 2'b01, 1'b1, 1'b0, "p_run4");
    expect_at(b + 13, 3'd3, 2'b10, 1'b1, 1'b0, "p_run3");
    expect_at(b + 15, 3'd3, 2'b10, 1'b1, 1'b0, "pre_pause");
    expect_at(b + 16, 3'd3, 2'b10, 1'b0, 1'b0, "paused");
    expect_at(b + 30, 3'd3, 2'b10, 1'b0, 1'b0, "paused");
    expect_at(b + 56, 3'd3, 2'b10, 1'b0, 1'b0, "paused");
    bus.btn_start = 1'b1;
    run(3);
    bus.btn_start = 1'b0;
    run(8);
    bus.btn_pause = 1'b1;
    run(3);
    bus.btn_pause = 1'b0;
    run(42);
    q = cyc_cnt;
    done_seen = 0;
    expect_at(q + 4, 3'd3, 2'b10, 1'b0, 1'b0, "resume_lat");
    expect_at(q + 5, 3'd3, 2'b10, 1'b1, 1'b0, "resumed");
    expect_at(q + 6, 3'd3, 2'b10, 1'b1, 1'b0, "resumed");
    expect_at(q + 7, 3'd2, 2'b10, 1'b1, 1'b0, "resume_dec");
    expect_at(q + 11, 3'd1, 2'b11, 1'b1, 1'b0, "r_run1");
    expect_at(q + 15, 3'd0, 2'b11, 1'b1, 1'b0, "r_run0");
    expect_at(q + 19, 3'd0, 2'b11, 1'b0, 1'b1, "r_done");
    expect_at(q + 20, 3'd0, 2'b11, 1'b0, 1'b0, "r_done_end");
    bus.btn_pause = 1'b1;
    run(3);
    bus.btn_pause = 1'b0;
    run(19);
    chk("done_count_c", 8'(done_seen), 8'd1);

    // Start and pause together at num=2: start wins
    b = cyc_cnt;
    expect_at(b + 5, 3'd5, 2'b01, 1'b1, 1'b0, "d_run5");
    expect_at(b + 17, 3'd2, 2'b10, 1'b1, 1'b0, "d_run2");
    expect_at(b + 18, 3'd2, 2'b10, 1'b1, 1'b0, "d_run2");
    expect_at(b + 19, 3'd5, 2'b01, 1'b1, 1'b0, "both_reload");
    expect_at(b + 22, 3'd5, 2'b01, 1'b1, 1'b0, "both_hold");
    expect_at(b + 23, 3'd4, 2'b01, 1'b1, 1'b0, "both_dec");
    expect_at(b + 31, 3'd2, 2'b10, 1'b1, 1'b0, "pre_reset");
    bus.btn_start = 1'b1;
    run(3);
    bus.btn_start = 1'b0;
    run(11);
    bus.btn_start = 1'b1;
    bus.btn_pause = 1'b1;
    run(3);
    bus.btn_start = 1'b0;
    bus.btn_pause = 1'b0;
    run(6);

    // Asynchronous reset mid-run with start held
    run(7);
    bus.btn_start = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    expect_at(cyc_cnt, 3'd5, 2'b00, 1'b0, 1'b0, "async_rst");
    drain();
    expect_at(cyc_cnt + 1, 3'd5, 2'b00, 1'b0, 1'b0, "in_rst");
    expect_at(cyc_cnt + 2, 3'd5, 2'b00, 1'b0, 1'b0, "in_rst");
    run(2);
    rst_n = 1'b1;
    b = cyc_cnt;
    expect_at(b + 2, 3'd5, 2'b00, 1'b0, 1'b0, "requal");
    expect_at(b + 4, 3'd5, 2'b00, 1'b0, 1'b0, "requal");
    expect_at(b + 5, 3'd5, 2'b01, 1'b1, 1'b0, "requal_run");
    expect_at(b + 6, 3'd5, 2'b01, 1'b1, 1'b0, "requal_run");
    run(6);
    bus.btn_start = 1'b0;
    run(2);

    chk("sb_empty", 8'(sb.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
